// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit model CPU: opcodes, sequencer states,
// phase-bit positions, register write-enable encodings and the strobe bundle.
package cpu_pkg;

  localparam logic [3:0] OP_MOVI = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_DIV  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_F_MAR,
    S_F_READ,
    S_F_IR,
    S_DECODE,
    S_I_MAR,
    S_I_READ,
    S_I_WB,
    S_X_ALU,
    S_X_WAIT,
    S_X_WB,
    S_HALTED
  } seq_state_t;

  // Phase bit in T for each state; immediate and ALU paths share T[4]/T[5].
  localparam int T_F_MAR  = 0;
  localparam int T_F_READ = 1;
  localparam int T_F_IR   = 2;
  localparam int T_DECODE = 3;
  localparam int T_I_MAR  = 4;
  localparam int T_I_READ = 5;
  localparam int T_I_WB   = 6;
  localparam int T_X_ALU  = 4;
  localparam int T_X_WAIT = 5;
  localparam int T_X_WB   = 7;

  localparam logic [3:0] IRX_R  = 4'b0001;
  localparam logic [3:0] IRX_AX = 4'b0010;
  localparam logic [3:0] IRX_DX = 4'b0100;
  localparam logic [3:0] IRX_CX = 4'b1000;

  // Registered control outputs, grouped so they are decoded and reset together.
  typedef struct packed {
    logic [7:0] t;
    logic       ipc;
    logic       imar;
    logic       idr;
    logic       edr;
    logic       iir;
    logic       ealu;
    logic [3:0] irx;
    logic       alu_start;
    logic       halt;
    logic       busy;
  } strobe_t;

  function automatic logic [3:0] irx_sel(input logic [1:0] dst);
    case (dst)
      2'd0:    return IRX_R;
      2'd1:    return IRX_AX;
      2'd2:    return IRX_DX;
      default: return IRX_CX;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hC) && (op <= 4'hE);
  endfunction

  function automatic logic is_multi_cycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/seq_timeout_ctr.sv
// Down-counter bounding how long the sequencer waits for a multi-cycle ALU
// result. Loaded on the way into the wait state; expired marks the last
// permitted wait cycle.
module seq_timeout_ctr #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic clear_n,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt_reg;

  // Load LIMIT-1 so that LIMIT wait cycles elapse before expiry; saturate at 0.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= W'(LIMIT - 1);
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign expired = (cnt_reg == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: one FSM drives the PC/MAR/DR/IR strobes,
// register write enables and ALU control, with run/halt/single-step control
// and a bounded wait for multi-cycle ALU operations.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int ALU_TIMEOUT = 16,
  parameter bit AUTO_RUN    = 1'b0
) (
  input  logic       clk,
  input  logic       CLEARn,
  input  logic       RUN,
  input  logic       STEP_MODE,
  input  logic       STEP,
  input  logic [7:0] IR,
  input  logic       ALU_DONE,
  output logic [7:0] T,
  output logic       IPC,
  output logic       IMAR,
  output logic       IDR,
  output logic       EDR,
  output logic       IIR,
  output logic       EALU,
  output logic [3:0] IRX,
  output logic [1:0] DST,
  output logic [1:0] SRC,
  output logic [3:0] ALU_OP,
  output logic       ALU_START,
  output logic       HALT,
  output logic       BUSY,
  output logic       ILLEGAL,
  output logic       ERR
);

  seq_state_t state_reg, state_next;
  strobe_t    strobe_reg, strobe_next;
  logic       run_d_reg;
  logic       boot_reg;
  logic [1:0] dst_reg, src_reg;
  logic [3:0] op_reg;
  logic       illegal_reg, err_reg;
  logic       wait_expired;
  logic [3:0] ir_op;
  logic       run_go;

  assign ir_op  = IR[7:4];
  assign run_go = RUN & ~STEP_MODE;

  seq_timeout_ctr #(
    .LIMIT(ALU_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .clear_n(CLEARn),
    .load   (state_reg == S_X_ALU),
    .dec    (state_reg == S_X_WAIT),
    .expired(wait_expired)
  );

  // Next-state logic: fetch, decode dispatch, execute paths and run control.
  always_comb begin
    seq_state_t end_state;
    state_next = state_reg;
    end_state  = run_go ? S_F_MAR : S_IDLE;
    case (state_reg)
      S_IDLE: begin
        if (run_go || (STEP_MODE && STEP) || boot_reg) begin
          state_next = S_F_MAR;
        end
      end
      S_F_MAR:  state_next = S_F_READ;
      S_F_READ: state_next = S_F_IR;
      S_F_IR:   state_next = S_DECODE;
      S_DECODE: begin
        if (ir_op == OP_MOVI) begin
          state_next = S_I_MAR;
        end else if (ir_op == OP_HLT) begin
          state_next = S_HALTED;
        end else if (is_illegal(ir_op)) begin
          state_next = end_state;
        end else begin
          state_next = S_X_ALU;
        end
      end
      S_I_MAR:  state_next = S_I_READ;
      S_I_READ: state_next = S_I_WB;
      S_I_WB:   state_next = end_state;
      S_X_ALU:  state_next = is_multi_cycle(op_reg) ? S_X_WAIT : S_X_WB;
      S_X_WAIT: begin
        if (ALU_DONE) begin
          state_next = S_X_WB;
        end else if (wait_expired) begin
          state_next = S_HALTED;
        end
      end
      S_X_WB:   state_next = end_state;
      S_HALTED: begin
        // An ALU timeout is fatal; only a fresh RUN edge resumes a HLT.
        if (!err_reg && RUN && !run_d_reg) begin
          state_next = S_F_MAR;
        end
      end
      default:  state_next = S_IDLE;
    endcase
  end

  // Strobe decode from the upcoming state so registered outputs align with it.
  always_comb begin
    strobe_next = '0;
    case (state_next)
      S_F_MAR: begin
        strobe_next.t[T_F_MAR] = 1'b1;
        strobe_next.imar       = 1'b1;
      end
      S_F_READ: begin
        strobe_next.t[T_F_READ] = 1'b1;
        strobe_next.idr         = 1'b1;
        strobe_next.ipc         = 1'b1;
      end
      S_F_IR: begin
        strobe_next.t[T_F_IR] = 1'b1;
        strobe_next.edr       = 1'b1;
        strobe_next.iir       = 1'b1;
      end
      S_DECODE: strobe_next.t[T_DECODE] = 1'b1;
      S_I_MAR: begin
        strobe_next.t[T_I_MAR] = 1'b1;
        strobe_next.imar       = 1'b1;
      end
      S_I_READ: begin
        strobe_next.t[T_I_READ] = 1'b1;
        strobe_next.idr         = 1'b1;
        strobe_next.ipc         = 1'b1;
      end
      S_I_WB: begin
        strobe_next.t[T_I_WB] = 1'b1;
        strobe_next.edr       = 1'b1;
        strobe_next.irx       = irx_sel(dst_reg);
      end
      S_X_ALU: begin
        strobe_next.t[T_X_ALU] = 1'b1;
        strobe_next.ealu       = 1'b1;
        strobe_next.alu_start  = 1'b1;
      end
      S_X_WAIT: begin
        strobe_next.t[T_X_WAIT] = 1'b1;
        strobe_next.ealu        = 1'b1;
      end
      S_X_WB: begin
        strobe_next.t[T_X_WB] = 1'b1;
        strobe_next.ealu      = 1'b1;
        strobe_next.irx       = irx_sel(dst_reg);
      end
      default: ;
    endcase
    strobe_next.halt = (state_next == S_HALTED);
    strobe_next.busy = (state_next != S_IDLE) && (state_next != S_HALTED);
  end

  // State, strobe and RUN-edge registers; AUTO_RUN arms a one-shot start.
  always_ff @(posedge clk) begin
    if (!CLEARn) begin
      state_reg  <= S_IDLE;
      strobe_reg <= '0;
      run_d_reg  <= 1'b0;
      boot_reg   <= AUTO_RUN;
    end else begin
      state_reg  <= state_next;
      strobe_reg <= strobe_next;
      run_d_reg  <= RUN;
      boot_reg   <= 1'b0;
    end
  end

  // Operand latch at DECODE plus the sticky ILLEGAL/ERR status flags.
  always_ff @(posedge clk) begin
    if (!CLEARn) begin
      dst_reg     <= 2'd0;
      src_reg     <= 2'd0;
      op_reg      <= 4'd0;
      illegal_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      if (state_reg == S_DECODE) begin
        dst_reg <= IR[3:2];
        src_reg <= IR[1:0];
        op_reg  <= ir_op;
        if (is_illegal(ir_op)) begin
          illegal_reg <= 1'b1;
        end
      end
      if ((state_reg == S_X_WAIT) && !ALU_DONE && wait_expired) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign T         = strobe_reg.t;
  assign IPC       = strobe_reg.ipc;
  assign IMAR      = strobe_reg.imar;
  assign IDR       = strobe_reg.idr;
  assign EDR       = strobe_reg.edr;
  assign IIR       = strobe_reg.iir;
  assign EALU      = strobe_reg.ealu;
  assign IRX       = strobe_reg.irx;
  assign ALU_START = strobe_reg.alu_start;
  assign HALT      = strobe_reg.halt;
  assign BUSY      = strobe_reg.busy;
  assign DST       = dst_reg;
  assign SRC       = src_reg;
  assign ALU_OP    = op_reg;
  assign ILLEGAL   = illegal_reg;
  assign ERR       = err_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a small PC/MAR/DR/IR/register-file
// datapath model so real instructions flow from a ROM image.
module tb_instr_sequencer;

  logic       clk;
  logic       CLEARn, RUN, STEP_MODE, STEP, ALU_DONE;
  logic [7:0] IR;
  logic [7:0] T;
  logic       IPC, IMAR, IDR, EDR, IIR, EALU, ALU_START, HALT, BUSY, ILLEGAL, ERR;
  logic [3:0] IRX, ALU_OP;
  logic [1:0] DST, SRC;

  int checks = 0;
  int errors = 0;

  instr_sequencer #(.ALU_TIMEOUT(16), .AUTO_RUN(1'b0)) dut (
    .clk(clk), .CLEARn(CLEARn), .RUN(RUN), .STEP_MODE(STEP_MODE), .STEP(STEP),
    .IR(IR), .ALU_DONE(ALU_DONE), .T(T), .IPC(IPC), .IMAR(IMAR), .IDR(IDR),
    .EDR(EDR), .IIR(IIR), .EALU(EALU), .IRX(IRX), .DST(DST), .SRC(SRC),
    .ALU_OP(ALU_OP), .ALU_START(ALU_START), .HALT(HALT), .BUSY(BUSY),
    .ILLEGAL(ILLEGAL), .ERR(ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- datapath model ----------------
  logic [7:0] rom [0:255];
  logic [7:0] pc, mar, dr, ir_q;
  logic [7:0] rf [0:3];
  logic       rf_clr;

  assign IR = ir_q;

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h1: return b;
      4'h2: return a + b;
      4'h3: return a - b;
      4'h4: return a * b;
      4'h5: return (b == 8'd0) ? 8'hFF : a / b;
      4'h6: return a | b;
      4'h7: return ~b;
      4'h8: return a & b;
      4'h9: return a ^ b;
      4'hA: return a << 1;
      4'hB: return a >> 1;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int k = 0; k < 4; k++) rf[k] <= 8'h00;
    end
    if (!CLEARn) begin
      pc <= 8'h00; mar <= 8'h00; dr <= 8'h00; ir_q <= 8'h00;
    end else begin
      if (IMAR) mar <= pc;
      if (IDR) dr <= rom[mar];
      if (IPC) pc <= pc + 8'd1;
      if (IIR) ir_q <= dr;
      for (int k = 0; k < 4; k++) begin
        if (IRX[k]) rf[k] <= EDR ? dr : alu_f(ALU_OP, rf[DST], rf[SRC]);
      end
    end
  end

  // ---------------- per-cycle stimulus and trace ----------------
  logic        run_v [0:63], step_v [0:63], done_v [0:63], clr_v [0:63];
  logic [7:0]  t_tr [0:63], op_tr [0:63], ax_tr [0:63], dx_tr [0:63];
  logic [3:0]  irx_tr [0:63];
  logic        ipc_tr [0:63], imar_tr [0:63], edr_tr [0:63], ealu_tr [0:63], start_tr [0:63];
  logic        halt_tr [0:63], busy_tr [0:63], ill_tr [0:63], err_tr [0:63];
  logic [30:0] all_tr [0:63];

  task automatic apply_reset(input logic sm, input logic run_lvl);
    @(negedge clk);
    CLEARn = 1'b0; RUN = 1'b0; STEP = 1'b0; ALU_DONE = 1'b0; STEP_MODE = sm; rf_clr = 1'b1;
    for (int a = 0; a < 256; a++) rom[a] = 8'hF0;
    for (int i = 0; i < 64; i++) begin
      run_v[i] = run_lvl; step_v[i] = 1'b0; done_v[i] = 1'b0; clr_v[i] = 1'b1;
    end
  endtask

  // Cycle i is sampled at its negedge, then the inputs for the edge ending it are driven.
  task automatic capture(input int n);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      t_tr[i] = T; irx_tr[i] = IRX; op_tr[i] = {4'h0, ALU_OP};
      ipc_tr[i] = IPC; imar_tr[i] = IMAR; edr_tr[i] = EDR; ealu_tr[i] = EALU;
      start_tr[i] = ALU_START; halt_tr[i] = HALT; busy_tr[i] = BUSY;
      ill_tr[i] = ILLEGAL; err_tr[i] = ERR; ax_tr[i] = rf[1]; dx_tr[i] = rf[2];
      all_tr[i] = {T, IPC, IMAR, IDR, EDR, IIR, EALU, IRX, DST, SRC, ALU_OP,
                   ALU_START, HALT, BUSY, ILLEGAL, ERR};
      rf_clr = 1'b0;
      CLEARn = clr_v[i]; RUN = run_v[i]; STEP = step_v[i]; ALU_DONE = done_v[i];
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset(1'b0, 1'b0);
    step_v[1] = 1'b1;
    capture(4);
    checks++; if (all_tr[0] !== 31'h0) begin errors++; $display("FAIL reset_outputs: got %h want 0", all_tr[0]); end
    checks++; if (all_tr[4] !== 31'h0) begin errors++; $display("FAIL idle_no_run_step_ignored: got %h want 0", all_tr[4]); end
    $display("test_reset: done");
  endtask

  task automatic test_movi();
    int n_ipc, n_irx;
    apply_reset(1'b0, 1'b1);
    rom[0] = 8'h04; rom[1] = 8'h5A;
    capture(8);
    n_ipc = 0; n_irx = 0;
    for (int i = 1; i <= 7; i++) begin
      if (ipc_tr[i]) n_ipc++;
      if (irx_tr[i] != 4'b0000) n_irx++;
    end
    checks++; if (t_tr[1] !== 8'h01 || imar_tr[1] !== 1'b1) begin errors++; $display("FAIL movi_fmar: got T=%h IMAR=%b want T=01 IMAR=1", t_tr[1], imar_tr[1]); end
    checks++; if (busy_tr[1] !== 1'b1) begin errors++; $display("FAIL movi_busy: got %b want 1", busy_tr[1]); end
    checks++; if (t_tr[4] !== 8'h08) begin errors++; $display("FAIL movi_decode: got %h want 08", t_tr[4]); end
    checks++; if (t_tr[7] !== 8'h40 || irx_tr[7] !== 4'b0010 || edr_tr[7] !== 1'b1) begin errors++; $display("FAIL movi_iwb: got T=%h IRX=%b EDR=%b want 40 0010 1", t_tr[7], irx_tr[7], edr_tr[7]); end
    checks++; if (n_ipc !== 2) begin errors++; $display("FAIL movi_ipc_count: got %0d want 2", n_ipc); end
    checks++; if (n_irx !== 1) begin errors++; $display("FAIL movi_irx_count: got %0d want 1", n_irx); end
    checks++; if (ax_tr[8] !== 8'h5A) begin errors++; $display("FAIL movi_ax: got %h want 5a", ax_tr[8]); end
    checks++; if (t_tr[8] !== 8'h01) begin errors++; $display("FAIL movi_next_fetch: got %h want 01", t_tr[8]); end
    $display("test_movi: done");
  endtask

  task automatic test_add();
    int n_ealu;
    apply_reset(1'b0, 1'b1);
    rom[0] = 8'h04; rom[1] = 8'h03; rom[2] = 8'h08; rom[3] = 8'h04; rom[4] = 8'h26;
    capture(21);
    n_ealu = 0;
    for (int i = 15; i <= 20; i++) if (ealu_tr[i]) n_ealu++;
    checks++; if (t_tr[15] !== 8'h01) begin errors++; $display("FAIL add_fmar: got %h want 01", t_tr[15]); end
    checks++; if (t_tr[19] !== 8'h10 || start_tr[19] !== 1'b1 || op_tr[19] !== 8'h02) begin errors++; $display("FAIL add_xalu: got T=%h START=%b OP=%h want 10 1 02", t_tr[19], start_tr[19], op_tr[19]); end
    checks++; if (t_tr[20] !== 8'h80 || irx_tr[20] !== 4'b0010 || start_tr[20] !== 1'b0) begin errors++; $display("FAIL add_xwb: got T=%h IRX=%b START=%b want 80 0010 0", t_tr[20], irx_tr[20], start_tr[20]); end
    checks++; if (n_ealu !== 2) begin errors++; $display("FAIL add_ealu_count: got %0d want 2", n_ealu); end
    checks++; if (ax_tr[21] !== 8'h07 || dx_tr[21] !== 8'h04) begin errors++; $display("FAIL add_result: got AX=%h DX=%h want 07 04", ax_tr[21], dx_tr[21]); end
    checks++; if (t_tr[21] !== 8'h01) begin errors++; $display("FAIL add_next_fetch: got %h want 01", t_tr[21]); end
    $display("test_add: done");
  endtask

  task automatic test_mul();
    apply_reset(1'b0, 1'b1);
    rom[0] = 8'h04; rom[1] = 8'h03; rom[2] = 8'h08; rom[3] = 8'h05; rom[4] = 8'h46;
    done_v[22] = 1'b1;
    capture(24);
    checks++; if (t_tr[20] !== 8'h20 || t_tr[22] !== 8'h20 || ealu_tr[22] !== 1'b1) begin errors++; $display("FAIL mul_wait: got T20=%h T22=%h EALU=%b want 20 20 1", t_tr[20], t_tr[22], ealu_tr[22]); end
    checks++; if (op_tr[21] !== 8'h04) begin errors++; $display("FAIL mul_op: got %h want 04", op_tr[21]); end
    checks++; if (t_tr[23] !== 8'h80 || irx_tr[23] !== 4'b0010) begin errors++; $display("FAIL mul_xwb: got T=%h IRX=%b want 80 0010", t_tr[23], irx_tr[23]); end
    checks++; if (ax_tr[24] !== 8'h0F || t_tr[24] !== 8'h01) begin errors++; $display("FAIL mul_result: got AX=%h T=%h want 0f 01", ax_tr[24], t_tr[24]); end
    // ALU_DONE already high during X_ALU: one X_WAIT cycle is still taken.
    apply_reset(1'b0, 1'b1);
    rom[0] = 8'h46;
    done_v[5] = 1'b1; done_v[6] = 1'b1;
    capture(8);
    checks++; if (t_tr[5] !== 8'h10 || t_tr[6] !== 8'h20) begin errors++; $display("FAIL mul_early_done_wait: got T5=%h T6=%h want 10 20", t_tr[5], t_tr[6]); end
    checks++; if (t_tr[7] !== 8'h80) begin errors++; $display("FAIL mul_early_done_xwb: got %h want 80", t_tr[7]); end
    $display("test_mul: done");
  endtask

  task automatic test_timeout();
    int n_irx;
    apply_reset(1'b0, 1'b1);
    rom[0] = 8'h46;
    run_v[23] = 1'b0;
    capture(27);
    n_irx = 0;
    for (int i = 0; i <= 27; i++) if (irx_tr[i] != 4'b0000) n_irx++;
    checks++; if (t_tr[21] !== 8'h20 || err_tr[21] !== 1'b0) begin errors++; $display("FAIL timeout_last_wait: got T=%h ERR=%b want 20 0", t_tr[21], err_tr[21]); end
    checks++; if (t_tr[22] !== 8'h00 || halt_tr[22] !== 1'b1 || err_tr[22] !== 1'b1 || busy_tr[22] !== 1'b0) begin errors++; $display("FAIL timeout_halt: got T=%h HALT=%b ERR=%b BUSY=%b want 00 1 1 0", t_tr[22], halt_tr[22], err_tr[22], busy_tr[22]); end
    checks++; if (n_irx !== 0) begin errors++; $display("FAIL timeout_no_write: got %0d writes want 0", n_irx); end
    checks++; if (halt_tr[27] !== 1'b1 || t_tr[27] !== 8'h00) begin errors++; $display("FAIL timeout_no_resume: got HALT=%b T=%h want 1 00", halt_tr[27], t_tr[27]); end
    $display("test_timeout: done");
  endtask

  task automatic test_step();
    apply_reset(1'b1, 1'b1);
    rom[0] = 8'h04; rom[1] = 8'h11; rom[2] = 8'h08; rom[3] = 8'h22;
    step_v[3] = 1'b1; step_v[14] = 1'b1;
    capture(22);
    checks++; if (t_tr[3] !== 8'h00 || busy_tr[3] !== 1'b0) begin errors++; $display("FAIL step_wait: got T=%h BUSY=%b want 00 0", t_tr[3], busy_tr[3]); end
    checks++; if (t_tr[4] !== 8'h01) begin errors++; $display("FAIL step1_fmar: got %h want 01", t_tr[4]); end
    checks++; if (t_tr[10] !== 8'h40 || irx_tr[10] !== 4'b0010) begin errors++; $display("FAIL step1_iwb: got T=%h IRX=%b want 40 0010", t_tr[10], irx_tr[10]); end
    checks++; if (t_tr[11] !== 8'h00 || busy_tr[11] !== 1'b0 || ax_tr[11] !== 8'h11) begin errors++; $display("FAIL step1_idle: got T=%h BUSY=%b AX=%h want 00 0 11", t_tr[11], busy_tr[11], ax_tr[11]); end
    checks++; if (t_tr[14] !== 8'h00 || t_tr[15] !== 8'h01) begin errors++; $display("FAIL step2_start: got T14=%h T15=%h want 00 01", t_tr[14], t_tr[15]); end
    checks++; if (t_tr[21] !== 8'h40 || irx_tr[21] !== 4'b0100) begin errors++; $display("FAIL step2_iwb: got T=%h IRX=%b want 40 0100", t_tr[21], irx_tr[21]); end
    checks++; if (busy_tr[22] !== 1'b0 || dx_tr[22] !== 8'h22) begin errors++; $display("FAIL step2_idle: got BUSY=%b DX=%h want 0 22", busy_tr[22], dx_tr[22]); end
    $display("test_step: done");
  endtask

  task automatic test_halt();
    apply_reset(1'b0, 1'b1);
    rom[0] = 8'hF0; rom[1] = 8'h04; rom[2] = 8'h33; rom[3] = 8'hF0;
    run_v[8] = 1'b0;
    capture(22);
    checks++; if (t_tr[4] !== 8'h08) begin errors++; $display("FAIL hlt_decode: got %h want 08", t_tr[4]); end
    checks++; if (t_tr[5] !== 8'h00 || halt_tr[5] !== 1'b1 || busy_tr[5] !== 1'b0) begin errors++; $display("FAIL hlt_halted: got T=%h HALT=%b BUSY=%b want 00 1 0", t_tr[5], halt_tr[5], busy_tr[5]); end
    checks++; if (halt_tr[8] !== 1'b1 || halt_tr[9] !== 1'b1) begin errors++; $display("FAIL hlt_run_held: got %b %b want 1 1", halt_tr[8], halt_tr[9]); end
    checks++; if (t_tr[10] !== 8'h01 || halt_tr[10] !== 1'b0) begin errors++; $display("FAIL hlt_resume: got T=%h HALT=%b want 01 0", t_tr[10], halt_tr[10]); end
    checks++; if (t_tr[16] !== 8'h40 || ax_tr[17] !== 8'h33) begin errors++; $display("FAIL hlt_resume_pc: got T=%h AX=%h want 40 33", t_tr[16], ax_tr[17]); end
    checks++; if (halt_tr[21] !== 1'b1 || err_tr[21] !== 1'b0) begin errors++; $display("FAIL hlt_second: got HALT=%b ERR=%b want 1 0", halt_tr[21], err_tr[21]); end
    $display("test_halt: done");
  endtask

  task automatic test_run_drop();
    apply_reset(1'b0, 1'b1);
    rom[0] = 8'h04; rom[1] = 8'h5A;
    for (int i = 3; i < 64; i++) run_v[i] = 1'b0;
    capture(10);
    checks++; if (t_tr[7] !== 8'h40 || irx_tr[7] !== 4'b0010) begin errors++; $display("FAIL rundrop_complete: got T=%h IRX=%b want 40 0010", t_tr[7], irx_tr[7]); end
    checks++; if (t_tr[8] !== 8'h00 || busy_tr[8] !== 1'b0 || ax_tr[8] !== 8'h5A) begin errors++; $display("FAIL rundrop_idle: got T=%h BUSY=%b AX=%h want 00 0 5a", t_tr[8], busy_tr[8], ax_tr[8]); end
    $display("test_run_drop: done");
  endtask

  task automatic test_clear_and_illegal();
    int n_irx;
    apply_reset(1'b0, 1'b1);
    rom[0] = 8'h46;
    clr_v[7] = 1'b0;
    capture(9);
    checks++; if (t_tr[7] !== 8'h20) begin errors++; $display("FAIL clr_wait_state: got %h want 20", t_tr[7]); end
    checks++; if (all_tr[8] !== 31'h0) begin errors++; $display("FAIL clr_xwait_outputs: got %h want 0", all_tr[8]); end
    checks++; if (t_tr[9] !== 8'h01) begin errors++; $display("FAIL clr_restart: got %h want 01", t_tr[9]); end

    apply_reset(1'b0, 1'b1);
    rom[0] = 8'h04; rom[1] = 8'h11; rom[2] = 8'h04; rom[3] = 8'h22;
    clr_v[13] = 1'b0;
    capture(15);
    checks++; if (t_tr[13] !== 8'h20 || all_tr[14] !== 31'h0) begin errors++; $display("FAIL clr_iread_outputs: got T13=%h all14=%h want 20 0", t_tr[13], all_tr[14]); end
    checks++; if (ax_tr[14] !== 8'h11 || ax_tr[15] !== 8'h11) begin errors++; $display("FAIL clr_iread_abort: got %h %h want 11 11", ax_tr[14], ax_tr[15]); end

    apply_reset(1'b0, 1'b1);
    rom[0] = 8'hC0;
    clr_v[9] = 1'b0;
    capture(10);
    n_irx = 0;
    for (int i = 0; i <= 9; i++) if (irx_tr[i] != 4'b0000) n_irx++;
    checks++; if (ill_tr[4] !== 1'b0 || ill_tr[5] !== 1'b1 || t_tr[5] !== 8'h01) begin errors++; $display("FAIL illegal_nop: got ILL4=%b ILL5=%b T5=%h want 0 1 01", ill_tr[4], ill_tr[5], t_tr[5]); end
    checks++; if (n_irx !== 0) begin errors++; $display("FAIL illegal_no_write: got %0d want 0", n_irx); end
    checks++; if (halt_tr[9] !== 1'b1 || ill_tr[9] !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got HALT=%b ILL=%b want 1 1", halt_tr[9], ill_tr[9]); end
    checks++; if (all_tr[10] !== 31'h0) begin errors++; $display("FAIL illegal_cleared: got %h want 0", all_tr[10]); end
    $display("test_clear_and_illegal: done");
  endtask

  initial begin
    CLEARn = 1'b0; RUN = 1'b0; STEP_MODE = 1'b0; STEP = 1'b0; ALU_DONE = 1'b0; rf_clr = 1'b1;
    test_reset();
    test_movi();
    test_add();
    test_mul();
    test_timeout();
    test_step();
    test_halt();
    test_run_drop();
    test_clear_and_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
